// File: rtl/tart_vis_window.sv
// Windowed visibility correlator for 1-bit complex samples: per-pair agreement
// counters over a programmable window, snapshotted into a streamed readout bank.

module tart_vis_pair #(
    parameter int WIDTH = 32,
    parameter int IBITS = 5,
    parameter int ACCUM = 18,
    parameter int K     = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             acc_i,
    input  logic             start_i,
    input  logic             end_i,
    input  logic             we_i,
    input  logic [IBITS-1:0] a_i,
    input  logic [IBITS-1:0] b_i,
    input  logic [WIDTH-1:0] re_i,
    input  logic [WIDTH-1:0] im_i,
    output logic [ACCUM-1:0] sum_re_o,
    output logic [ACCUM-1:0] sum_im_o
);
    localparam logic [IBITS-1:0] RST_B = IBITS'((K + 1) % WIDTH);

    logic [IBITS-1:0] sh_a_q, sh_b_q, act_a_q, act_b_q, a, b;
    logic [ACCUM-1:0] acc_re_q, acc_im_q;
    logic             ra, rb, ia, ib;
    logic [1:0]       inc_re, inc_im;

    always_comb begin
        // The first sample of a window already uses the table it is about to latch.
        a        = start_i ? sh_a_q : act_a_q;
        b        = start_i ? sh_b_q : act_b_q;
        ra       = re_i[a];
        rb       = re_i[b];
        ia       = im_i[a];
        ib       = im_i[b];
        inc_re   = {1'b0, ra == rb} + {1'b0, ia == ib};
        inc_im   = {1'b0, ia == rb} + {1'b0, ra != ib};
        sum_re_o = acc_re_q + ACCUM'(inc_re);
        sum_im_o = acc_im_q + ACCUM'(inc_im);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_a_q   <= '0;
            sh_b_q   <= RST_B;
            act_a_q  <= '0;
            act_b_q  <= RST_B;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            if (we_i) begin
                sh_a_q <= a_i;
                sh_b_q <= b_i;
            end
            if (start_i) begin
                act_a_q <= sh_a_q;
                act_b_q <= sh_b_q;
            end
            if (!en_i || (acc_i && end_i)) begin
                acc_re_q <= '0;
                acc_im_q <= '0;
            end else if (acc_i) begin
                acc_re_q <= sum_re_o;
                acc_im_q <= sum_im_o;
            end
        end
    end
endmodule

module tart_vis_window #(
    parameter int WIDTH = 32,
    parameter int PAIRS = 8,
    parameter int COUNT = 15,
    parameter int ACCUM = 18,
    parameter int IBITS = $clog2(WIDTH),
    parameter int PBITS = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] re_i,
    input  logic [WIDTH-1:0] im_i,
    input  logic [COUNT-1:0] cfg_len_i,
    input  logic             cfg_we_i,
    input  logic [PBITS-1:0] cfg_idx_i,
    input  logic [IBITS-1:0] cfg_a_i,
    input  logic [IBITS-1:0] cfg_b_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [ACCUM-1:0] m_data_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             ovf_o,
    input  logic             clr_ovf_i
);
    localparam int WORDS = 2 * PAIRS;
    localparam int IDXW  = $clog2(WORDS);

    generate
        if (ACCUM < COUNT + 2) begin : g_bad_accum
            $error("tart_vis_window: ACCUM must be >= COUNT+2");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                       state_q;
    logic [IDXW-1:0]              idx_q;
    logic [ACCUM-1:0]             data_q;
    logic                         last_q, ovf_q;
    logic [COUNT-1:0]             cnt_q, len_q, eff_len;
    logic [PAIRS-1:0][ACCUM-1:0]  sum_re, sum_im, snap_re_q, snap_im_q;
    logic                         accept, start, win_end, last_hs, load;

    assign accept  = valid_i && en_i;
    assign start   = accept && (cnt_q == '0);
    assign eff_len = (cnt_q == '0) ? cfg_len_i : len_q;
    assign win_end = accept && (cnt_q == eff_len);
    assign last_hs = (state_q == SEND) && m_ready_i && last_q;
    // A window closing exactly on the last handshake chains straight into a new frame.
    assign load    = win_end && ((state_q == IDLE) || last_hs);

    genvar k;
    generate
        for (k = 0; k < PAIRS; k++) begin : g_pair
            tart_vis_pair #(.WIDTH(WIDTH), .IBITS(IBITS), .ACCUM(ACCUM), .K(k)) u_pair (
                .clock   (clock),
                .reset_n (reset_n),
                .en_i    (en_i),
                .acc_i   (accept),
                .start_i (start),
                .end_i   (win_end),
                .we_i    (cfg_we_i && (cfg_idx_i == PBITS'(k))),
                .a_i     (cfg_a_i),
                .b_i     (cfg_b_i),
                .re_i    (re_i),
                .im_i    (im_i),
                .sum_re_o(sum_re[k]),
                .sum_im_o(sum_im[k])
            );
        end
    endgenerate

    function automatic logic [ACCUM-1:0] word_of(input logic [IDXW-1:0] w);
        logic [PBITS-1:0] p;
        p = PBITS'(w >> 1);
        return w[0] ? snap_im_q[p] : snap_re_q[p];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= win_end ? '0 : cnt_q + 1'b1;
            if (start) len_q <= cfg_len_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_re_q <= '0;
            snap_im_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (load) begin
                snap_re_q <= sum_re;
                snap_im_q <= sum_im;
            end
            if (win_end && (state_q == SEND) && !last_hs) ovf_q <= 1'b1;
            else if (clr_ovf_i)                           ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    state_q <= SEND;
                    idx_q   <= '0;
                    data_q  <= sum_re[0];
                    last_q  <= 1'b0;
                end
                SEND: if (load) begin
                    idx_q   <= '0;
                    data_q  <= sum_re[0];
                    last_q  <= 1'b0;
                end else if (m_ready_i) begin
                    if (last_q) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        data_q <= word_of(idx_q + 1'b1);
                        last_q <= ((idx_q + 1'b1) == IDXW'(WORDS - 1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid_o = (state_q == SEND);
    assign busy_o    = (state_q == SEND);
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_tart_vis_window.sv
// Directed bench for tart_vis_window: table of constant-sample windows plus
// hand-written shadow-table, overflow, boundary, disable and reset sequences.

module tb_tart_vis_window;
    logic        clock = 0, reset_n = 1, en_i = 0, valid_i = 0;
    logic [31:0] re_i = 0, im_i = 0;
    logic [14:0] cfg_len_i = 0;
    logic        cfg_we_i = 0;
    logic [2:0]  cfg_idx_i = 0;
    logic [4:0]  cfg_a_i = 0, cfg_b_i = 0;
    logic        m_valid_o, m_ready_i = 0, m_last_o, busy_o, ovf_o, clr_ovf_i = 0;
    logic [17:0] m_data_o;

    int checks = 0, failures = 0;

    tart_vis_window dut (
        .clock(clock), .reset_n(reset_n), .en_i(en_i), .valid_i(valid_i),
        .re_i(re_i), .im_i(im_i), .cfg_len_i(cfg_len_i), .cfg_we_i(cfg_we_i),
        .cfg_idx_i(cfg_idx_i), .cfg_a_i(cfg_a_i), .cfg_b_i(cfg_b_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_last_o(m_last_o), .busy_o(busy_o), .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] re;
        logic [31:0] im;
        int          len;
        int          er[8];
        int          ei[8];
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic feed(input logic [31:0] re, input logic [31:0] im, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            valid_i = 1; re_i = re; im_i = im;
        end
        @(negedge clock);
        valid_i = 0;
    endtask

    task automatic read_frame(input string nm, input int er[8], input int ei[8],
                              input bit inj, input logic [31:0] ire, input logic [31:0] iim);
        for (int w = 0; w < 16; w++) begin
            chk($sformatf("%s valid w%0d", nm, w), 32'(m_valid_o), 32'd1);
            chk($sformatf("%s data w%0d", nm, w), 32'(m_data_o),
                32'((w % 2) ? ei[w/2] : er[w/2]));
            chk($sformatf("%s last w%0d", nm, w), 32'(m_last_o), 32'(w == 15));
            m_ready_i = 1;
            if (inj && w == 15) begin
                valid_i = 1; re_i = ire; im_i = iim;
            end
            @(negedge clock);
            valid_i = 0;
        end
        m_ready_i = 0;
    endtask

    task automatic fill(output int a[8], input int v);
        for (int i = 0; i < 8; i++) a[i] = v;
    endtask

    int e84r[8], e84i[8], esr[8], esi[8], e21r[8], e21i[8], e12r[8], e12i[8], e48r[8], e48i[8];

    initial begin
        vecs[0].name = "all_agree";  vecs[0].re = 32'hFFFF_FFFF; vecs[0].im = 32'hFFFF_FFFF; vecs[0].len = 3;
        vecs[0].er = '{8, 8, 8, 8, 8, 8, 8, 8}; vecs[0].ei = '{4, 4, 4, 4, 4, 4, 4, 4};
        vecs[1].name = "ant0_only";  vecs[1].re = 32'h0000_0001; vecs[1].im = 32'h0000_0000; vecs[1].len = 1;
        vecs[1].er = '{2, 2, 2, 2, 2, 2, 2, 2}; vecs[1].ei = '{4, 4, 4, 4, 4, 4, 4, 4};
        vecs[2].name = "quadrature"; vecs[2].re = 32'h0000_0003; vecs[2].im = 32'h0000_0001; vecs[2].len = 0;
        vecs[2].er = '{1, 0, 0, 0, 0, 0, 0, 0}; vecs[2].ei = '{2, 1, 1, 1, 1, 1, 1, 1};
        vecs[3].name = "mixed";      vecs[3].re = 32'hAAAA_AAAA; vecs[3].im = 32'h0000_00F0; vecs[3].len = 2;
        vecs[3].er = '{3, 6, 3, 3, 0, 3, 0, 6}; vecs[3].ei = '{0, 3, 0, 6, 3, 6, 3, 3};

        fill(e84r, 8); fill(e84i, 4);
        esr = e84r; esi = e84i; esr[2] = 4; esi[2] = 0;
        fill(e21r, 2); fill(e21i, 1);
        fill(e12r, 1); fill(e12i, 2);
        fill(e48r, 4); fill(e48i, 8);

        #1 reset_n = 0;
        repeat (2) @(negedge clock);
        chk("rst valid", 32'(m_valid_o), 0);
        chk("rst last", 32'(m_last_o), 0);
        chk("rst data", 32'(m_data_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst ovf", 32'(ovf_o), 0);
        reset_n = 1; en_i = 1;

        for (int v = 0; v < 4; v++) begin
            cfg_len_i = 15'(vecs[v].len);
            feed(vecs[v].re, vecs[v].im, vecs[v].len + 1);
            read_frame(vecs[v].name, vecs[v].er, vecs[v].ei, 0, 0, 0);
            chk({vecs[v].name, " idle valid"}, 32'(m_valid_o), 0);
            chk({vecs[v].name, " idle busy"}, 32'(busy_o), 0);
        end

        // Shadow write of pair 2 mid-window only shows up in the next window.
        cfg_len_i = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            valid_i = 1; re_i = 32'h0000_0200; im_i = 0;
            cfg_we_i = (i == 1); cfg_idx_i = 2; cfg_a_i = 5; cfg_b_i = 9;
        end
        @(negedge clock);
        valid_i = 0; cfg_we_i = 0;
        read_frame("shadow_cur", e84r, e84i, 0, 0, 0);
        feed(32'h0000_0200, 0, 4);
        read_frame("shadow_next", esr, esi, 0, 0, 0);
        @(negedge clock);
        cfg_we_i = 1; cfg_idx_i = 2; cfg_a_i = 0; cfg_b_i = 3;
        @(negedge clock);
        cfg_we_i = 0;

        // Back-pressure with a second window landing on a held frame.
        cfg_len_i = 0;
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        chk("ovf pre", 32'(ovf_o), 0);
        feed(32'h0000_0001, 0, 1);
        chk("ovf set", 32'(ovf_o), 1);
        chk("ovf busy", 32'(busy_o), 1);
        repeat (3) @(negedge clock);
        chk("ovf hold data", 32'(m_data_o), 2);
        chk("ovf hold last", 32'(m_last_o), 0);
        read_frame("ovf_keep", e21r, e21i, 0, 0, 0);
        chk("ovf sticky", 32'(ovf_o), 1);
        clr_ovf_i = 1;
        @(negedge clock);
        clr_ovf_i = 0;
        chk("ovf clr", 32'(ovf_o), 0);
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        @(negedge clock);
        valid_i = 1; re_i = 0; im_i = 0; clr_ovf_i = 1;
        @(negedge clock);
        valid_i = 0; clr_ovf_i = 0;
        chk("ovf set wins", 32'(ovf_o), 1);
        read_frame("ovf_keep2", e21r, e21i, 0, 0, 0);
        clr_ovf_i = 1;
        @(negedge clock);
        clr_ovf_i = 0;

        // Window end on the same edge as the last-word handshake.
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        read_frame("bnd_a", e21r, e21i, 1, 32'h0000_0001, 0);
        chk("bnd ovf", 32'(ovf_o), 0);
        chk("bnd chain valid", 32'(m_valid_o), 1);
        read_frame("bnd_b", e12r, e12i, 0, 0, 0);
        chk("bnd end ovf", 32'(ovf_o), 0);

        // Disable mid-window discards the partial accumulation.
        cfg_len_i = 3;
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        en_i = 0;
        @(negedge clock);
        en_i = 1;
        chk("dis no frame", 32'(m_valid_o), 0);
        feed(32'h0000_0001, 0, 4);
        read_frame("disable", e48r, e48i, 0, 0, 0);

        // Reset in the middle of a frame and of a window.
        cfg_len_i = 0;
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        m_ready_i = 1;
        repeat (3) @(negedge clock);
        m_ready_i = 0;
        cfg_len_i = 3;
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        reset_n = 0;
        #1;
        chk("mid rst valid", 32'(m_valid_o), 0);
        chk("mid rst data", 32'(m_data_o), 0);
        chk("mid rst last", 32'(m_last_o), 0);
        chk("mid rst busy", 32'(busy_o), 0);
        chk("mid rst ovf", 32'(ovf_o), 0);
        @(negedge clock);
        reset_n = 1;
        repeat (3) @(negedge clock);
        chk("post rst no frame", 32'(m_valid_o), 0);
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        chk("post rst partial", 32'(m_valid_o), 0);
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        read_frame("post_rst", e84r, e84i, 0, 0, 0);
        chk("post rst idle", 32'(m_valid_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tart_vis_window.md
# tart_vis_window

Windowed visibility correlator for 1-bit complex antenna samples. It accumulates real and imaginary agreement counts over a programmable window for a run-time-selectable set of antenna pairs. Each finished window is snapshotted into a readout bank and streamed out over a valid/ready interface while the next window accumulates. It sits between the sample capture front-end and the visibility readout/bus bridge, and generalises the fixed-width correlator core with:
- configurable pair count
- a programmable pair table
- programmable window length
- double-buffered streaming readout with overflow detection

## Interface
- WIDTH, 32, antenna channels per sample.
- PAIRS, 8, correlated antenna pairs (≥1).
- COUNT, 15, window-length register bits; a window holds up to 2^COUNT samples.
- ACCUM, 18, accumulator/output word bits. Must satisfy ACCUM ≥ COUNT+2; elaboration fails otherwise.
- IBITS, $clog2(WIDTH), antenna index bits.
- PBITS, $clog2(PAIRS), pair index bits.
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- en_i  in  1  correlation enable.
- valid_i  in  1  sample strobe.
- re_i  in  WIDTH  real sign bits (1 = +1, 0 = −1).
- im_i  in  WIDTH  imaginary sign bits.
- cfg_len_i  in  COUNT  window length minus one.
- cfg_we_i  in  1  pair-table write strobe.
- cfg_idx_i  in  PBITS  pair-table entry to write.
- cfg_a_i, cfg_b_i  in  IBITS  antenna indices for that entry.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  ACCUM  output word.
- m_last_o  out  1  final word of a frame.
- busy_o  out  1  readout bank holds an undrained frame.
- ovf_o  out  1  sticky overflow flag.
- clr_ovf_i  in  1  clears ovf_o.

## Operation
**Arithmetic.** For pair k with antennas a, b and one accepted sample (valid_i & en_i):
- real count += (re[a]==re[b]) + (im[a]==im[b])
- imag count += (im[a]==re[b]) + (re[a]!=im[b])
- Each increment is 0..2. Counts are unsigned and never wrap, guaranteed by the ACCUM ≥ COUNT+2 rule.
- Software converts: Re = 2·real − 2N, Im = 2·imag − 2N, where N is the number of samples in the window.

**Window control.**
- The sample counter counts accepted samples.
- At window start the block latches len = cfg_len_i and copies the shadow pair table into the active table.
- The window ends on the accepted sample where counter == len.
- That sample is included in the snapshot. Accumulators and counter restart from zero for the next accepted sample.

**Pair table.**
- cfg_we_i writes the shadow entry cfg_idx_i = (a, b) in the next cycle.
- The write takes effect only at the next window start. An in-progress window is never altered.
- Reset value of entry k: a = 0, b = (k+1) mod WIDTH.

**Enable.** en_i low: the counter and accumulators clear at the next edge, discarding the partial window. The table reloads when en_i rises. Readout is unaffected.

**Readout FSM**, states IDLE and SEND:
- IDLE→SEND when a window ends: snapshot loads, word index = 0.
- In SEND, the frame is 2·PAIRS words in order real0, imag0, real1, imag1, …
- The index advances on m_valid_o & m_ready_i.
- m_last_o is high with the final word. Its handshake returns the FSM to IDLE.
- m_valid_o = (state==SEND). busy_o = (state==SEND).

**Overflow.**
- A window end while in SEND, other than on the cycle the last word handshakes: snapshot not updated, ovf_o set, accumulators still restart.
- A window end coinciding with the last-word handshake: new snapshot loads, stay in SEND, index = 0, no overflow.
- clr_ovf_i clears ovf_o. If clr_ovf_i and a new overflow coincide, set wins.

## Timing
- Reset values: m_valid_o = 0, m_last_o = 0, m_data_o = 0, busy_o = 0, ovf_o = 0, counter and accumulators = 0, FSM = IDLE, both tables at reset pattern, len = 0.
- Accumulation is single-cycle: the sample accepted at edge t is visible in the accumulators after edge t.
- m_valid_o rises one cycle after the edge that accepts the window's final sample.
- Peak rate is one word per cycle with m_ready_i held high. A frame takes 2·PAIRS cycles.
- reset_n asserted mid-window or mid-frame: everything returns to reset values immediately, with no partial frame afterwards.
- m_data_o and m_last_o are registered and stable while m_valid_o & !m_ready_i.

## Test plan
- **Reset defaults, all-agree.** WIDTH=32, PAIRS=8, cfg_len_i=3, re=im=all ones for 4 samples → one frame of 16 words, all real = 8 and imag = 4 (Re = 8, Im = 0); m_last_o only on word 15.
- **Quadrature.** Pair 0 = (0, 1), ant0 = (+1, +1), ant1 = (+1, −1), cfg_len_i=0 → real0 = 1, imag0 = 2 (Re = 0, Im = +2).
- **Shadow table.** Write pair 2 = (5, 9) mid-window → current frame uses (0, 3); the following frame uses (5, 9).
- **Overflow and back-pressure.** m_ready_i = 0 and two windows of length 1 → ovf_o = 1, first frame retained intact. clr_ovf_i → ovf_o = 0.
- **Exact boundary.** Window end on the same cycle as the last-word handshake → new frame starts next cycle, ovf_o stays 0.
- **Disable and reset.** en_i low mid-window, or reset_n pulsed mid-frame → partial data discarded, outputs at reset values; next full window yields exact counts.
